hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage pipeline.
- Drives the EN (hold) and CLR (clear) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the EX-stage operand forwarding muxes.
- Handles three hazards: load-use stalls, taken-branch/jump flushes, and multi-cycle data-memory waits, including a wait timeout.
- Keeps saturating performance counters for stall cycles and flushes.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hazard_pkg;

  // Default register-address width (32 architectural registers)
  localparam int REG_AW_DEF = 5;

  // Memory-wait controller states
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // EX-stage operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: count reflects an increment one clock after inc is sampled.
// Backpressure: none; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count events, holding at all-ones once saturated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with perf counters.
// Latency: stall/flush/forward are combinational; mem_timeout and counters are registered.
// Backpressure: a pending data-memory access holds every stage up to EX/MEM and bubbles MEM/WB.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int CNT_W       = 32,
  // Longest number of MEM_WAIT cycles before the access is abandoned (2..65535)
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              load_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              pc_src_e,
  input  logic              mem_req_m,
  input  logic              mem_ack,
  input  logic              clr_cnt,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  // wait_cnt value on the last MEM_WAIT cycle allowed before abort
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           mem_hold;
  logic           load_use;
  logic           branch_flush;

  // Forwarding select for one EX source operand; MEM result is newer than WB, x0 never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              wr_m,
    input logic [REG_AW-1:0] dst_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] dst_w
  );
    if (wr_m && (dst_m != '0) && (dst_m == rs)) begin
      return FWD_MEM;
    end else if (wr_w && (dst_w != '0) && (dst_w == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  // Hazard detection and prioritised stall/flush generation
  always_comb begin
    mem_hold = !mem_ack &&
               (((state == RUN) && mem_req_m && !mem_timeout) || (state == MEM_WAIT));
    load_use = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    stall_m      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_w      = 1'b0;
    branch_flush = 1'b0;

    if (!rst) begin
      // pipeline control stays inert while in reset
    end else if (mem_hold) begin
      // freeze everything up to EX/MEM; a branch in EX waits here and flushes later
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      // wrong-path instructions in ID and EX are squashed; any load-use in ID dies with them
      flush_d      = 1'b1;
      flush_e      = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      // one bubble: the load moves to MEM next cycle, clearing the dependency
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Operand forwarding muxes for EX
  always_comb begin
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (rst) begin
      fwd_a_e = fwd_sel(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
      fwd_b_e = fwd_sel(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
    end
  end

  // Memory-wait FSM with abort after MEM_TIMEOUT cycles in MEM_WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          mem_timeout <= 1'b0;
          wait_cnt    <= '0;
          if (mem_hold) begin
            state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state       <= RUN;
          wait_cnt    <= '0;
          mem_timeout <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_f),
    .clr   (clr_cnt),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_flush),
    .clr   (clr_cnt),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a reference model.
module tb_hazard_ctrl;

  localparam int REG_AW      = 5;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              load_e, reg_write_m, reg_write_w, pc_src_e;
  logic              mem_req_m, mem_ack, clr_cnt;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_w;
  logic [1:0]        fwd_a_e, fwd_b_e;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_cycles, flush_count;

  hazard_ctrl #(
    .REG_AW      (REG_AW),
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rs1_e        (rs1_e),
    .rs2_e        (rs2_e),
    .rd_e         (rd_e),
    .rd_m         (rd_m),
    .rd_w         (rd_w),
    .load_e       (load_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .pc_src_e     (pc_src_e),
    .mem_req_m    (mem_req_m),
    .mem_ack      (mem_ack),
    .clr_cnt      (clr_cnt),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_w      (flush_w),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             sf, sd, se, sm, fd, fe, fw;
    logic [1:0]       fa, fb;
    logic             to;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  bit m_waiting;   // a memory access is outstanding past its request cycle
  int m_waited;    // wait cycles already spent on the outstanding access
  bit m_to;        // abort pulse visible this cycle
  int m_sc, m_fc;  // counter values visible this cycle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Predict this cycle's outputs from the current inputs, queue them, advance the model one clock
  task automatic apply();
    exp_t e;
    bit   hold, lu;
    e = '0;
    if (!rst) begin
      m_waiting = 0; m_waited = 0; m_to = 0; m_sc = 0; m_fc = 0;
      q.push_back(e);
    end else begin
      hold = !mem_ack && (m_waiting || (mem_req_m && !m_to));
      lu   = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      if (hold) begin
        e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
      end else if (pc_src_e) begin
        e.fd = 1; e.fe = 1;
      end else if (lu) begin
        e.sf = 1; e.sd = 1; e.fe = 1;
      end
      e.fa = ref_fwd(rs1_e);
      e.fb = ref_fwd(rs2_e);
      e.to = m_to;
      e.sc = CNT_W'(m_sc);
      e.fc = CNT_W'(m_fc);
      q.push_back(e);

      if (clr_cnt) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (e.sf) m_sc = sat_inc(m_sc);
        if (!hold && pc_src_e) m_fc = sat_inc(m_fc);
      end

      if (m_waiting) begin
        if (mem_ack) begin
          m_waiting = 0; m_waited = 0; m_to = 0;
        end else if (m_waited + 1 == MEM_TIMEOUT) begin
          m_waiting = 0; m_waited = 0; m_to = 1;
        end else begin
          m_waited++;
        end
      end else begin
        m_to = 0;
        if (hold) begin
          m_waiting = 1; m_waited = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; reg_write_m = 0; reg_write_w = 0; pc_src_e = 0;
    mem_req_m = 0; mem_ack = 0; clr_cnt = 0;
  endtask

  // Monitor: compare the DUT against the oldest prediction mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall_f",      32'(stall_f),      32'(e.sf));
        chk("stall_d",      32'(stall_d),      32'(e.sd));
        chk("stall_e",      32'(stall_e),      32'(e.se));
        chk("stall_m",      32'(stall_m),      32'(e.sm));
        chk("flush_d",      32'(flush_d),      32'(e.fd));
        chk("flush_e",      32'(flush_e),      32'(e.fe));
        chk("flush_w",      32'(flush_w),      32'(e.fw));
        chk("fwd_a_e",      32'(fwd_a_e),      32'(e.fa));
        chk("fwd_b_e",      32'(fwd_b_e),      32'(e.fb));
        chk("mem_timeout",  32'(mem_timeout),  32'(e.to));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
        chk("flush_count",  32'(flush_count),  32'(e.fc));
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    apply(); apply();
    rst = 1'b1;

    // load-use on rs1, then a load to x0 that must not stall
    idle(); load_e = 1; rd_e = 5; rs1_d = 5; apply();
    idle(); apply();
    load_e = 1; rd_e = 0; rs1_d = 0; apply();
    idle(); apply();

    // forwarding: MEM beats WB, then WB alone, rs2 unmatched
    reg_write_m = 1; reg_write_w = 1; rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 3; apply();
    reg_write_m = 0; apply();
    idle(); apply();

    // memory wait: four unacked cycles then ack
    mem_req_m = 1; repeat (4) apply();
    mem_ack = 1; apply();
    idle(); apply();

    // branch together with load-use
    pc_src_e = 1; load_e = 1; rd_e = 5; rs1_d = 5; apply();
    idle(); apply();

    // branch held in EX during a memory wait
    mem_req_m = 1; pc_src_e = 1; repeat (2) apply();
    mem_ack = 1; apply();
    mem_req_m = 0; mem_ack = 0; apply();
    idle(); apply();

    // timeout: request never acknowledged
    mem_req_m = 1; repeat (8) apply();
    idle(); apply();

    // clear colliding with an increment
    load_e = 1; rd_e = 9; rs2_d = 9; clr_cnt = 1; apply();
    idle(); apply();

    // reset in the middle of a wait
    mem_req_m = 1; repeat (3) apply();
    rst = 1'b0; apply(); apply();
    rst = 1'b1; idle(); apply();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) != 0);
      rs1_d       = REG_AW'($urandom_range(0, 7));
      rs2_d       = REG_AW'($urandom_range(0, 7));
      rs1_e       = REG_AW'($urandom_range(0, 7));
      rs2_e       = REG_AW'($urandom_range(0, 7));
      rd_e        = REG_AW'($urandom_range(0, 7));
      rd_m        = REG_AW'($urandom_range(0, 7));
      rd_w        = REG_AW'($urandom_range(0, 7));
      load_e      = ($urandom_range(0, 2) == 0);
      reg_write_m = ($urandom_range(0, 1) == 0);
      reg_write_w = ($urandom_range(0, 1) == 0);
      pc_src_e    = ($urandom_range(0, 5) == 0);
      mem_req_m   = ($urandom_range(0, 2) == 0);
      mem_ack     = ($urandom_range(0, 2) == 0);
      clr_cnt     = ($urandom_range(0, 39) == 0);
      apply();
    end

    idle();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
